// File: rtl/core_db_rr_sched_if.sv
// Handshake bundle between requesters, the shared core_db datapath and the
// round-robin scheduler. The slave modport is the scheduler's view.
interface core_db_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 7
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  logic              dp_valid;
  logic [W-1:0]      dp_data;
  logic              dp_ready;

  logic              dp_rvalid;
  logic [W-1:0]      dp_rdata;
  logic              dp_rready;

  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [NREQ-1:0]   rsp_ready;

  modport master (
    output req_valid, req_data, dp_ready, dp_rvalid, dp_rdata, rsp_ready,
    input  req_ready, dp_valid, dp_data, dp_rready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, dp_ready, dp_rvalid, dp_rdata, rsp_ready,
    output req_ready, dp_valid, dp_data, dp_rready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/core_db_rr_sched.sv
// Round-robin scheduler sharing one core_db datapath between NREQ requesters;
// issued words are tagged so in-order results route back to their sender.
module core_db_rr_sched #(
  parameter int NREQ  = 4,
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  core_db_rr_sched_if.slave      bus,
  output logic [$clog2(DEPTH):0] inflight_o,
  output logic                   proto_err_o
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slotState_e;

  slotState_e    slotState_q, slotState_d;
  logic [W-1:0]  slotData_q, slotData_d;
  logic [TW-1:0] slotTag_q, slotTag_d;
  logic [TW-1:0] rrPtr_q, rrPtr_d;
  logic [TW-1:0] tagMem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          protoErr_q, protoErr_d;

  logic          slotFull;
  logic          issue;
  logic          canGrant;
  logic          grantValid;
  logic [TW-1:0] grantIdx;
  logic [TW-1:0] headTag;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic          strayResult;
  logic          dpRready;
  logic [NREQ-1:0] rspValid;
  logic [W-1:0]  reqWord [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_reqWord
    assign reqWord[gi] = bus.req_data[gi*W +: W];
  end

  assign slotFull  = (slotState_q == SLOT_FULL);
  assign issue     = slotFull & bus.dp_ready;
  assign push      = issue;
  assign fifoEmpty = (count_q == '0);
  assign headTag   = tagMem_q[rdPtr_q];

  // Room is reserved for the word already sitting in the slot, so a grant
  // can never push the tag FIFO past DEPTH.
  assign canGrant = (!slotFull || bus.dp_ready) &&
                    ((int'(count_q) + int'(slotFull)) < DEPTH);

  always_comb begin
    logic [TW:0]   sum;
    logic [TW-1:0] cand;
    grantValid = 1'b0;
    grantIdx   = '0;
    sum        = '0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rrPtr_q} + (TW+1)'(i);
      if (sum >= (TW+1)'(NREQ)) begin
        sum = sum - (TW+1)'(NREQ);
      end
      cand = sum[TW-1:0];
      if (!grantValid && bus.req_valid[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
    if (!canGrant || rst_i) begin
      grantValid = 1'b0;
      grantIdx   = '0;
    end
  end

  assign bus.req_ready = grantValid ? (NREQ'(1) << grantIdx) : '0;

  // Issue slot: a new grant reloads it even while the old word leaves,
  // which is what sustains one word per cycle.
  always_comb begin
    slotState_d = slotState_q;
    slotData_d  = slotData_q;
    slotTag_d   = slotTag_q;
    rrPtr_d     = rrPtr_q;
    if (grantValid) begin
      slotState_d = SLOT_FULL;
      slotData_d  = reqWord[grantIdx];
      slotTag_d   = grantIdx;
      rrPtr_d     = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + TW'(1);
    end else if (issue) begin
      slotState_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    rspValid    = '0;
    dpRready    = 1'b0;
    pop         = 1'b0;
    strayResult = 1'b0;
    if (!rst_i) begin
      if (!fifoEmpty) begin
        rspValid[headTag] = bus.dp_rvalid;
        dpRready          = bus.rsp_ready[headTag];
        pop               = bus.dp_rvalid & bus.rsp_ready[headTag];
      end else begin
        dpRready    = 1'b1;
        strayResult = bus.dp_rvalid;
      end
    end
  end

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    wrPtr_d    = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    protoErr_d = protoErr_q | strayResult;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slotState_q <= SLOT_EMPTY;
      slotData_q  <= '0;
      slotTag_q   <= '0;
      rrPtr_q     <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      protoErr_q  <= 1'b0;
    end else begin
      slotState_q <= slotState_d;
      slotData_q  <= slotData_d;
      slotTag_q   <= slotTag_d;
      rrPtr_q     <= rrPtr_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      protoErr_q  <= protoErr_d;
    end
  end

  // Tag storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tagMem_q[wrPtr_q] <= slotTag_q;
    end
  end

  assign bus.dp_valid  = slotFull;
  assign bus.dp_data   = slotData_q;
  assign bus.dp_rready = dpRready;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_data  = bus.dp_rdata;
  assign inflight_o    = count_q;
  assign proto_err_o   = protoErr_q;
endmodule

// File: tb/tb_core_db_rr_sched.sv
// Bench for core_db_rr_sched: directed scenarios plus randomized traffic,
// all compared against a queue-based transaction model.
module tb_core_db_rr_sched;
  localparam int NREQ  = 4;
  localparam int W     = 7;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] inflight;
  logic       protoErr;

  core_db_rr_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  core_db_rr_sched #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .inflight_o  (inflight),
    .proto_err_o (protoErr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: slot contents, pointer, sticky error and the queue of requester
  // ids whose words are inside the datapath, oldest first.
  int mSlotValid, mSlotData, mSlotTag, mRr, mProto;
  int tagQ[$];

  int              eGrant;
  logic [NREQ-1:0] eReqReady;
  logic [NREQ-1:0] eRspValid;
  logic            eDpRready;

  logic [3:0] expGrant [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mSlotValid = 0;
    mSlotData  = 0;
    mSlotTag   = 0;
    mRr        = 0;
    mProto     = 0;
    tagQ.delete();
  endfunction

  function automatic void computeExpected();
    int j;
    eGrant = -1;
    if ((mSlotValid == 0 || bus.dp_ready) && (tagQ.size() + mSlotValid < DEPTH)) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (mRr + k) % NREQ;
        if (eGrant < 0 && bus.req_valid[j]) eGrant = j;
      end
    end
    eReqReady = (eGrant >= 0) ? NREQ'(1) << eGrant : '0;
    if (tagQ.size() > 0) begin
      eRspValid = bus.dp_rvalid ? NREQ'(1) << tagQ[0] : '0;
      eDpRready = bus.rsp_ready[tagQ[0]];
    end else begin
      eRspValid = '0;
      eDpRready = 1'b1;
    end
  endfunction

  function automatic void modelUpdate();
    int issue;
    issue = (mSlotValid != 0 && bus.dp_ready) ? 1 : 0;
    if (tagQ.size() > 0) begin
      if (bus.dp_rvalid && bus.rsp_ready[tagQ[0]]) void'(tagQ.pop_front());
    end else if (bus.dp_rvalid) begin
      mProto = 1;
    end
    if (issue != 0) tagQ.push_back(mSlotTag);
    if (eGrant >= 0) begin
      mSlotValid = 1;
      mSlotData  = int'(bus.req_data[eGrant*W +: W]);
      mSlotTag   = eGrant;
      mRr        = (eGrant + 1) % NREQ;
    end else if (issue != 0) begin
      mSlotValid = 0;
    end
  endfunction

  // Called at posedge+1; samples at the falling edge against the model.
  task automatic sampleCheck(input string tag);
    #4;
    computeExpected();
    checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'(eReqReady));
    checkOutput({tag, ".dp_valid"},  32'(bus.dp_valid),  32'(mSlotValid));
    if (mSlotValid != 0) checkOutput({tag, ".dp_data"}, 32'(bus.dp_data), 32'(mSlotData));
    checkOutput({tag, ".dp_rready"}, 32'(bus.dp_rready), 32'(eDpRready));
    checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(eRspValid));
    if (eRspValid != '0) checkOutput({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(bus.dp_rdata));
    checkOutput({tag, ".inflight"},  32'(inflight),      32'(tagQ.size()));
    checkOutput({tag, ".proto_err"}, 32'(protoErr),      32'(mProto));
  endtask

  task automatic advance();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyReset(input string tag);
    rst = 1'b1;
    #1;
    checkOutput({tag, ".rst_dp_valid"},  32'(bus.dp_valid),  32'd0);
    checkOutput({tag, ".rst_inflight"},  32'(inflight),      32'd0);
    checkOutput({tag, ".rst_req_ready"}, 32'(bus.req_ready), 32'd0);
    checkOutput({tag, ".rst_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, ".rst_dp_rready"}, 32'(bus.dp_rready), 32'd0);
    checkOutput({tag, ".rst_proto_err"}, 32'(protoErr),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus();
    bus.req_valid = NREQ'($urandom);
    bus.req_data  = (NREQ*W)'($urandom);
    bus.dp_ready  = ($urandom_range(0, 3) != 0);
    bus.rsp_ready = NREQ'($urandom);
    bus.dp_rdata  = W'($urandom);
    if (tagQ.size() > 0) bus.dp_rvalid = ($urandom_range(0, 1) != 0);
    else                 bus.dp_rvalid = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.dp_ready  = 1'b0;
    bus.dp_rvalid = 1'b0;
    bus.dp_rdata  = '0;
    bus.rsp_ready = '1;
    modelReset();
    #1;

    // Reset with every requester asking, then first grant goes to 0.
    applyReset("t1");
    sampleCheck("t1");
    checkOutput("t1.first_grant", 32'(bus.req_ready), 32'd1);
    advance();

    // Full-throughput round robin with results returned every cycle.
    applyReset("t2");
    bus.req_valid = '1;
    bus.req_data  = {7'h04, 7'h03, 7'h02, 7'h01};
    bus.dp_ready  = 1'b1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 6; c++) begin
      bus.dp_rvalid = (tagQ.size() > 0);
      bus.dp_rdata  = W'($urandom);
      sampleCheck("t2");
      if (c < 5) checkOutput("t2.grant", 32'(bus.req_ready), 32'(expGrant[c]));
      if (c >= 1 && c <= 4) checkOutput("t2.dp_data", 32'(bus.dp_data), 32'(c));
      advance();
    end
    bus.dp_rvalid = 1'b0;

    // Backpressure then fill to DEPTH with no results coming back.
    applyReset("t3");
    bus.req_valid = '1;
    bus.req_data  = {7'h44, 7'h33, 7'h22, 7'h11};
    bus.dp_ready  = 1'b0;
    sampleCheck("t3");
    checkOutput("t3.grant0", 32'(bus.req_ready), 32'd1);
    advance();
    for (int c = 0; c < 3; c++) begin
      sampleCheck("t3");
      checkOutput("t3.stall_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("t3.stall_data",  32'(bus.dp_data),   32'h11);
      advance();
    end
    bus.dp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sampleCheck("t3");
      advance();
    end
    sampleCheck("t3");
    checkOutput("t3.full_inflight",  32'(inflight),      32'd4);
    checkOutput("t3.full_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("t3.full_dp_valid",  32'(bus.dp_valid),  32'd0);
    advance();

    // Routing back to requesters 2 then 1, with a held response.
    applyReset("t4");
    bus.req_data  = {7'h00, 7'h15, 7'h2A, 7'h00};
    bus.dp_ready  = 1'b1;
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0100;
    sampleCheck("t4");
    advance();
    bus.req_valid = 4'b0010;
    sampleCheck("t4");
    advance();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      sampleCheck("t4");
      advance();
    end
    bus.dp_rvalid = 1'b1;
    bus.dp_rdata  = 7'h55;
    bus.rsp_ready = 4'b1011;
    for (int c = 0; c < 2; c++) begin
      sampleCheck("t4");
      checkOutput("t4.hold_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      checkOutput("t4.hold_rsp_data",  32'(bus.rsp_data),  32'h55);
      checkOutput("t4.hold_dp_rready", 32'(bus.dp_rready), 32'd0);
      advance();
    end
    bus.rsp_ready = '1;
    sampleCheck("t4");
    checkOutput("t4.rsp0_valid", 32'(bus.rsp_valid), 32'h4);
    advance();
    bus.dp_rdata = 7'h66;
    sampleCheck("t4");
    checkOutput("t4.rsp1_valid", 32'(bus.rsp_valid), 32'h2);
    checkOutput("t4.rsp1_data",  32'(bus.rsp_data),  32'h66);
    advance();
    bus.dp_rvalid = 1'b0;
    sampleCheck("t4");
    checkOutput("t4.drained", 32'(inflight), 32'd0);
    advance();

    // Stray result with nothing in flight sets the sticky error.
    applyReset("t5");
    bus.dp_rvalid = 1'b1;
    sampleCheck("t5");
    checkOutput("t5.stray_rready", 32'(bus.dp_rready), 32'd1);
    checkOutput("t5.stray_rsp",    32'(bus.rsp_valid), 32'd0);
    advance();
    bus.dp_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sampleCheck("t5");
      advance();
    end
    checkOutput("t5.sticky", 32'(protoErr), 32'd1);

    // Asynchronous reset while the slot is full and three words are in flight.
    applyReset("t6a");
    bus.req_valid = '1;
    bus.req_data  = (NREQ*W)'($urandom);
    bus.dp_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (tagQ.size() == 3 && mSlotValid != 0) break;
      sampleCheck("t6");
      advance();
    end
    checkOutput("t6.setup_inflight", 32'(inflight),     32'd3);
    checkOutput("t6.setup_dp_valid", 32'(bus.dp_valid), 32'd1);
    applyReset("t6b");
    sampleCheck("t6");
    checkOutput("t6.grant0", 32'(bus.req_ready), 32'd1);
    advance();

    for (int c = 0; c < 600; c++) begin
      applyStimulus();
      sampleCheck("rnd");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
